commit_unit: RTL



---
 rtl/commit_unit_pkg.sv | 38 +++
 rtl/commit_unit_if.sv | 25 ++
 rtl/commit_unit_tag_lookup.sv | 27 ++
 rtl/commit_unit.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/commit_unit_pkg.sv
// Shared types for commit_unit: buffer entry and store request.
// The optional COMMIT_PERF_EN counters live in commit_unit.sv.
package commit_unit_pkg;
  localparam int BUF_SIZE = 8;
  localparam int BUF_SIZE_LOG = $clog2(BUF_SIZE);
  localparam int TAG_W = BUF_SIZE_LOG + 1;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ISSUED,
    S_EXECUTED
  } e_state_t;

  typedef enum logic [1:0] {
    ALU,
    LOAD,
    STORE,
    BRANCH
  } unit_t;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [BUF_SIZE_LOG-1:0] idx_t;

  typedef struct packed {
    e_state_t    e_state;
    tag_t        tag;
    unit_t       Unit;
    logic [2:0]  rwmm;
    logic [31:0] A;
    logic [31:0] Vk;
  } entry_t;

  typedef struct packed {
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] data;
  } store_req_t;
endpackage

// File: rtl/commit_unit_if.sv
// Store-queue head to data-memory write port handshake.
// Master drives the head store, slave returns ready.
interface commit_unit_if;
  logic        store_valid;
  logic        store_ready;
  logic [2:0]  store_mode;
  logic [31:0] store_addr;
  logic [31:0] store_data;

  modport master (
    output store_valid,
    output store_mode,
    output store_addr,
    output store_data,
    input  store_ready
  );

  modport slave (
    input  store_valid,
    input  store_mode,
    input  store_addr,
    input  store_data,
    output store_ready
  );
endinterface

// File: rtl/commit_unit_tag_lookup.sv
// Finds the single executed buffer entry holding a given tag.
// multi flags the illegal case of more than one hit.
module tag_lookup
  import commit_unit_pkg::*;
(
  input  entry_t entries [BUF_SIZE],
  input  tag_t   tag,
  output logic   hit,
  output idx_t   idx,
  output logic   multi
);
  int n;

  always_comb begin
    n = 0;
    idx = '0;
    for (int i = 0; i < BUF_SIZE; i++) begin
      if (entries[i].e_state == S_EXECUTED &&
          entries[i].tag == tag) begin
        n = n + 1;
        idx = idx_t'(i);
      end
    end
    hit = (n == 1);
    multi = (n > 1);
  end
endmodule

// File: rtl/commit_unit.sv
// In-order commit stage with registered store queue.
// Define COMMIT_PERF_EN for perf_commits / perf_sq_stalls.
module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int COMMIT_WIDTH = 2,
  parameter int SQ_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  entry_t                  entries [BUF_SIZE],
  output logic [COMMIT_WIDTH-1:0] commit_valid,
  output idx_t                    commit_idx [COMMIT_WIDTH],
  output tag_t                    commit_tag [COMMIT_WIDTH],
  output logic [COMMIT_WIDTH-1:0] commit_is_store,
  output logic                    sq_empty,
`ifdef COMMIT_PERF_EN
  output logic [31:0]             perf_commits,
  output logic [31:0]             perf_sq_stalls,
`endif
  commit_unit_if.master           sq
);
  localparam int PTR_W = $clog2(SQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  tag_t             head_tag_q, head_tag_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  store_req_t       mem_q [SQ_DEPTH];
  store_req_t       mem_d [SQ_DEPTH];

  logic [COMMIT_WIDTH-1:0] hit, multi;
  idx_t hit_idx [COMMIT_WIDTH];
  logic pop, sq_stall;
  int   n_commit, n_push;

  for (genvar k = 0; k < COMMIT_WIDTH; k++) begin : g_slot
    tag_lookup u_lookup (
      .entries (entries),
      .tag     (head_tag_q + tag_t'(k)),
      .hit     (hit[k]),
      .idx     (hit_idx[k]),
      .multi   (multi[k])
    );
  end

  // Free space is taken from the start-of-cycle count only.
  always_comb begin
    int   free;
    int   stores;
    logic ok;
    logic st;
    free = SQ_DEPTH - int'(count_q);
    stores = 0;
    ok = !rst;
    sq_stall = 1'b0;
    n_commit = 0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      st = (entries[hit_idx[k]].Unit == STORE);
      commit_valid[k] = 1'b0;
      commit_idx[k] = '0;
      commit_tag[k] = '0;
      commit_is_store[k] = 1'b0;
      if (ok && hit[k]) begin
        if (stores + int'(st) <= free) begin
          commit_valid[k] = 1'b1;
          commit_idx[k] = hit_idx[k];
          commit_tag[k] = head_tag_q + tag_t'(k);
          commit_is_store[k] = st;
          stores = stores + int'(st);
          n_commit = n_commit + 1;
        end else begin
          sq_stall = 1'b1;
          ok = 1'b0;
        end
      end else begin
        ok = 1'b0;
      end
    end
    n_push = stores;
  end

  always_comb begin
    logic [PTR_W-1:0] wp;
    store_req_t       req;
    mem_d = mem_q;
    wp = wptr_q;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      req.mode = entries[commit_idx[k]].rwmm;
      req.addr = entries[commit_idx[k]].A;
      req.data = entries[commit_idx[k]].Vk;
      if (commit_valid[k] && commit_is_store[k]) begin
        mem_d[wp] = req;
        wp = wp + PTR_W'(1);
      end
    end
    wptr_d = wp;
    pop = (count_q != '0) && sq.store_ready;
    rptr_d = rptr_q + PTR_W'(pop);
    count_d = CNT_W'(int'(count_q) + n_push - int'(pop));
    head_tag_d = head_tag_q + tag_t'(n_commit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_tag_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      head_tag_q <= head_tag_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign sq.store_valid = (count_q != '0);
  assign sq.store_mode =
    sq.store_valid ? mem_q[rptr_q].mode : '0;
  assign sq.store_addr =
    sq.store_valid ? mem_q[rptr_q].addr : '0;
  assign sq.store_data =
    sq.store_valid ? mem_q[rptr_q].data : '0;
  assign sq_empty = (count_q == '0);

  a_single_match: assert property (
    @(posedge clk) disable iff (rst) multi == '0
  );

`ifdef COMMIT_PERF_EN
  logic [31:0] perf_commits_q, perf_commits_d;
  logic [31:0] perf_sq_stalls_q, perf_sq_stalls_d;

  always_comb begin
    perf_commits_d = perf_commits_q + 32'(n_commit);
    perf_sq_stalls_d = perf_sq_stalls_q + 32'(sq_stall);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_commits_q <= '0;
      perf_sq_stalls_q <= '0;
    end else begin
      perf_commits_q <= perf_commits_d;
      perf_sq_stalls_q <= perf_sq_stalls_d;
    end
  end

  assign perf_commits = perf_commits_q;
  assign perf_sq_stalls = perf_sq_stalls_q;
`endif
endmodule
